// File: rtl/alu_mux_pkg.sv
// Shared constants for the ALU operand selector family.
package alu_mux_pkg;

  localparam int DEF_WIDTH = 32;

  // Level of the err flag when the select points past the last channel.
  localparam logic SEL_ERR = 1'b1;

endpackage

// File: rtl/alu_mux_sel.sv
// Combinational N-input operand select with out-of-range flag.
// Out-of-range selects return zero data so downstream never sees stale channels.
module alu_mux_sel
  import alu_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_IN   = 2,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_err
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] w_chan [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign w_chan[gi] = i_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Constant-false when NUM_IN is a power of two.
  assign o_err = ({1'b0, i_sel} >= NUM_IN_W) ? SEL_ERR : ~SEL_ERR;

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (i_sel == SEL_W'(k)) o_data = w_chan[k];
    end
  end

endmodule

// File: rtl/alu_mux_pipe.sv
// Registered operand selector with valid/ready handshake and a one-entry skid buffer.
// in_ready comes straight from state, so there is no combinational path from out_ready.
module alu_mux_pipe
  import alu_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_IN   = 2,
  localparam int SEL_W   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t           r_state, w_state_next;
  beat_t            r_or, r_sr, w_beat;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_in_xfer, w_out_xfer;
  logic             w_or_load, w_or_from_sr, w_sr_load;

  alu_mux_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_sel_data),
    .o_err  (w_sel_err)
  );

  assign w_beat     = {w_sel_data, in_sel, w_sel_err};
  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_or.data;
  assign out_sel    = r_or.sel;
  assign out_err    = r_or.err;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_next = r_state;
    w_or_load    = 1'b0;
    w_or_from_sr = 1'b0;
    w_sr_load    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_or_load    = 1'b1;
          w_state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_or_load = 1'b1;
        end else if (w_in_xfer) begin
          // Downstream stalled: park the new beat behind the output register.
          w_sr_load    = 1'b1;
          w_state_next = ST_FULL;
        end else if (w_out_xfer) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_or_from_sr = 1'b1;
          w_state_next = ST_ONE;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_or    <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_or_load)         r_or <= w_beat;
      else if (w_or_from_sr) r_or <= r_sr;
      if (w_sr_load)         r_sr <= w_beat;
      else if (w_or_from_sr) r_sr <= '0;
    end
  end

endmodule

// File: tb/tb_alu_mux_pipe.sv
// Bench for alu_mux_pipe: directed checks on 2- and 3-input instances, scoreboarded stress on a 5-input one.
module tb_alu_mux_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v2, rdy2, ov2, ordy2, oe2, s2, os2;
  logic [63:0] d2;
  logic [31:0] od2;

  logic        v3, rdy3, ov3, ordy3, oe3;
  logic [95:0] d3;
  logic [1:0]  s3, os3;
  logic [31:0] od3;

  logic        v5, rdy5, ov5, ordy5, oe5;
  logic [79:0] d5;
  logic [2:0]  s5, os5;
  logic [15:0] od5;

  alu_mux_pipe #(.WIDTH(32), .NUM_IN(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_sel(s2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_sel(os2), .out_err(oe2));

  alu_mux_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3), .in_sel(s3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_sel(os3), .out_err(oe3));

  alu_mux_pipe #(.WIDTH(16), .NUM_IN(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(rdy5), .in_data(d5), .in_sel(s5),
    .out_valid(ov5), .out_ready(ordy5), .out_data(od5), .out_sel(os5), .out_err(oe5));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec3_t;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  s;
    logic        e;
  } exp5_t;

  vec3_t tbl [6];
  exp5_t sb [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on u5: randomise inputs, score pre-edge transfers, check stall stability after the edge.
  task automatic cycle5(input bit v, input bit r, output bit acc, output bit was_blocked);
    exp5_t e;
    bit pre_out, stall;
    logic [15:0] snap_d;
    logic [2:0]  snap_s;
    logic        snap_e;
    v5    = v;
    ordy5 = r;
    if (v) begin
      s5 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 5; k++) d5[k*16 +: 16] = 16'($urandom);
    end else begin
      s5 = 'x;
      d5 = 'x;
    end
    acc         = v5 && rdy5;
    was_blocked = !rdy5;
    pre_out     = ov5 && ordy5;
    stall       = ov5 && !ordy5;
    snap_d = od5; snap_s = os5; snap_e = oe5;
    if (pre_out) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_beat", {44'h0, od5, os5, oe5}, {44'h0, e.d, e.s, e.e});
      end
    end
    if (acc) begin
      e.s = s5;
      e.e = (s5 >= 3'd5);
      e.d = e.e ? 16'h0 : d5[int'(s5)*16 +: 16];
      sb.push_back(e);
    end
    step();
    if (stall) chk("stall_hold", {43'h0, ov5, od5, os5, oe5}, {43'h0, 1'b1, snap_d, snap_s, snap_e});
  endtask

  initial begin
    bit acc, blk;
    int accepted, cyc, lows;

    tbl[0] = '{2'd0, 32'h1111_1111, 1'b0};
    tbl[1] = '{2'd1, 32'h2222_2222, 1'b0};
    tbl[2] = '{2'd2, 32'h3333_3333, 1'b0};
    tbl[3] = '{2'd3, 32'h0000_0000, 1'b1};
    tbl[4] = '{2'd2, 32'h3333_3333, 1'b0};
    tbl[5] = '{2'd1, 32'h2222_2222, 1'b0};

    // Reset with every input driven active.
    rst_n = 1'b0;
    v2 = 1; d2 = {$urandom, $urandom}; s2 = 1; ordy2 = 1;
    v3 = 1; d3 = {$urandom, $urandom, $urandom}; s3 = 2; ordy3 = 1;
    v5 = 1; d5 = {16'h1, $urandom, $urandom}; s5 = 1; ordy5 = 1;
    step(); step();
    rst_n = 1'b1; v2 = 0; v3 = 0; v5 = 0;
    chk("rst_ov2", 64'(ov2), 0);   chk("rst_od2", 64'(od2), 0);  chk("rst_rdy2", 64'(rdy2), 1);
    chk("rst_os2", 64'(os2), 0);   chk("rst_oe2", 64'(oe2), 0);
    chk("rst_ov3", 64'(ov3), 0);   chk("rst_rdy3", 64'(rdy3), 1);
    chk("rst_ov5", 64'(ov5), 0);   chk("rst_od5", 64'(od5), 0);  chk("rst_rdy5", 64'(rdy5), 1);
    step();
    chk("idle_ov2", 64'(ov2), 0);  chk("idle_rdy2", 64'(rdy2), 1);

    // Two-input select on consecutive cycles.
    d2 = {32'h5555_0000, 32'h0000_00AA};
    v2 = 1; s2 = 0; step();
    chk("sel0_ov", 64'(ov2), 1); chk("sel0_d", 64'(od2), 64'h0000_00AA); chk("sel0_e", 64'(oe2), 0);
    s2 = 1; step();
    chk("sel1_d", 64'(od2), 64'h5555_0000); chk("sel1_s", 64'(os2), 1); chk("sel1_e", 64'(oe2), 0);
    v2 = 0; step();
    chk("sel_drain_ov", 64'(ov2), 0);

    // Backpressure fills the skid, then releases in order.
    ordy2 = 0; s2 = 0; v2 = 1;
    d2 = 64'd1; step();
    chk("bp_d1", 64'(od2), 1); chk("bp_rdy_one", 64'(rdy2), 1);
    d2 = 64'd2; step();
    chk("bp_full_rdy", 64'(rdy2), 0); chk("bp_full_d", 64'(od2), 1);
    d2 = 64'd3; step();
    chk("bp_d3_block_rdy", 64'(rdy2), 0); chk("bp_d3_block_d", 64'(od2), 1);
    ordy2 = 1; step();
    chk("bp_out2", 64'(od2), 2); chk("bp_out2_v", 64'(ov2), 1); chk("bp_rdy_back", 64'(rdy2), 1);
    step();
    chk("bp_out3", 64'(od2), 3); chk("bp_out3_v", 64'(ov2), 1);
    v2 = 0; step();
    chk("bp_empty", 64'(ov2), 0);

    // Table-driven three-input selects, including an out-of-range one.
    d3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    ordy3 = 1; v3 = 1;
    for (int i = 0; i < 6; i++) begin
      s3 = tbl[i].sel;
      step();
      chk($sformatf("tbl%0d_v", i), 64'(ov3), 1);
      chk($sformatf("tbl%0d_d", i), 64'(od3), 64'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_e", i), 64'(oe3), 64'(tbl[i].exp_e));
      chk($sformatf("tbl%0d_s", i), 64'(os3), 64'(tbl[i].sel));
    end
    v3 = 0; step();

    // Reset while FULL discards both stored beats.
    ordy3 = 0; v3 = 1; s3 = 0; step();
    s3 = 1; step();
    chk("full_rdy3", 64'(rdy3), 0);
    rst_n = 0; v3 = 0; step();
    rst_n = 1;
    chk("rstfull_ov", 64'(ov3), 0); chk("rstfull_rdy", 64'(rdy3), 1);
    ordy3 = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rstfull_stale%0d", i), 64'(ov3), 0);
    end

    // Random stress on the five-input instance.
    accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      cycle5(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), acc, blk);
      if (acc) accepted++;
      cyc++;
    end
    chk("stress_beats", 64'(accepted), 64'd10000);
    for (int i = 0; i < 4; i++) cycle5(1'b0, 1'b1, acc, blk);

    // Full throughput with a single one-cycle downstream bubble.
    accepted = 0; lows = 0;
    for (int i = 0; i < 100; i++) begin
      cycle5(1'b1, (i != 50), acc, blk);
      if (acc) accepted++;
      if (blk) lows++;
    end
    chk("tput_accepted", 64'(accepted), 64'd99);
    chk("tput_ready_lows", 64'(lows), 64'd1);
    for (int i = 0; i < 4; i++) cycle5(1'b0, 1'b1, acc, blk);
    chk("drain_sb_empty", 64'(sb.size()), 0);
    chk("drain_ov5", 64'(ov5), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
